// File: rtl/fxp_sumsq_pipe.sv
// Sum-of-squares / plain-sum over NUM_CH unsigned fixed-point channels, saturated
// to DATAWIDTH+1 bits, followed by a stall-able register pipeline with bubble collapse.
module fxp_sumsq_pipe #(
  parameter int DATAWIDTH           = 16,
  parameter int FRAC_BITS           = 8,
  parameter int NUM_CH              = 4,
  parameter int NUM_PIPELINE_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  output logic                          i_ready,
  input  logic                          i_mode,
  input  logic [NUM_CH*DATAWIDTH-1:0]   i_data,
  output logic                          o_valid,
  input  logic                          o_ready,
  output logic [DATAWIDTH:0]            o_data,
  output logic                          o_sat
);

  localparam int S     = NUM_PIPELINE_STAGES + 1;
  // Wide enough for NUM_CH (<=16) full squares or plain channel values.
  localparam int SUM_W = 2*DATAWIDTH + 5;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  // Producers hold valid/data until accepted; ready never depends on valid.

  logic [DATAWIDTH-1:0]   ch;
  logic [2*DATAWIDTH-1:0] sq;
  logic [SUM_W-1:0]       sum;
  logic                   sat_c;
  logic [DATAWIDTH:0]     data_c;

  always_comb begin
    ch  = '0;
    sq  = '0;
    sum = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      ch = i_data[c*DATAWIDTH +: DATAWIDTH];
      sq = {{DATAWIDTH{1'b0}}, ch} * {{DATAWIDTH{1'b0}}, ch};
      if (i_mode) sum = sum + SUM_W'(ch);
      else        sum = sum + SUM_W'(sq >> FRAC_BITS);
    end
    sat_c  = |sum[SUM_W-1:DATAWIDTH+1];
    data_c = sat_c ? '1 : sum[DATAWIDTH:0];
  end

  logic [S-1:0]       vld;
  logic [S-1:0]       stg_sat;
  logic [DATAWIDTH:0] stg_data [S];
  logic [S-1:0]       en;
  logic               run;

  // A stage may load when it, or any stage after it, is empty, or the output drains.
  always_comb begin
    en  = '0;
    run = o_ready;
    for (int k = S-1; k >= 0; k--) begin
      run   = run | ~vld[k];
      en[k] = run;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld     <= '0;
      stg_sat <= '0;
      for (int k = 0; k < S; k++) stg_data[k] <= '0;
    end else begin
      if (en[0]) begin
        vld[0]      <= i_valid;
        stg_data[0] <= data_c;
        stg_sat[0]  <= sat_c;
      end
      for (int k = 1; k < S; k++) begin
        if (en[k]) begin
          vld[k]      <= vld[k-1];
          stg_data[k] <= stg_data[k-1];
          stg_sat[k]  <= stg_sat[k-1];
        end
      end
    end
  end

  assign i_ready = en[0];
  assign o_valid = vld[S-1];
  assign o_data  = stg_data[S-1];
  assign o_sat   = stg_sat[S-1];

endmodule

// File: tb/tb_fxp_sumsq_pipe.sv
// Directed and randomized bench for fxp_sumsq_pipe at default parameters,
// checked against an arithmetic reference model and an in-order expected queue.
module tb_fxp_sumsq_pipe;

  localparam int DW = 16;
  localparam int FB = 8;
  localparam int NC = 4;
  localparam int NP = 2;
  localparam int S  = NP + 1;
  localparam int W  = DW + 2;  // {sat, data}

  logic              clk;
  logic              rst;
  logic              i_valid;
  logic              i_ready;
  logic              i_mode;
  logic [NC*DW-1:0]  i_data;
  logic              o_valid;
  logic              o_ready;
  logic [DW:0]       o_data;
  logic              o_sat;

  fxp_sumsq_pipe #(
    .DATAWIDTH(DW), .FRAC_BITS(FB), .NUM_CH(NC), .NUM_PIPELINE_STAGES(NP)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_mode(i_mode), .i_data(i_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_sat(o_sat)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  bit           stall_prev = 1'b0;
  logic [DW:0]  hold_d;
  logic         hold_s;

  function automatic logic [W-1:0] model(logic [NC*DW-1:0] d, logic m);
    longint unsigned sum, v;
    sum = 0;
    for (int c = 0; c < NC; c++) begin
      v = longint'(d[c*DW +: DW]);
      if (m) sum = sum + v;
      else   sum = sum + ((v * v) >> FB);
    end
    if (sum > (64'd1 << (DW+1)) - 1) return {1'b1, {(DW+1){1'b1}}};
    return {1'b0, sum[DW:0]};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called just after a falling edge with inputs already driven.
  task automatic cycle(output bit in_fire);
    logic [W-1:0] e;
    #1;
    in_fire = i_valid && i_ready && !rst;
    if (!rst) begin
      if (stall_prev) begin
        check("stall_valid", o_valid, 1);
        check("stall_data", o_data, hold_d);
        check("stall_sat", o_sat, hold_s);
      end
      if (exp_q.size() == 0) begin
        check("no_spurious_valid", o_valid, 0);
      end else if (o_valid && o_ready) begin
        e = exp_q.pop_front();
        check("out_data", o_data, e[DW:0]);
        check("out_sat", o_sat, e[DW+1]);
      end
    end
    if (in_fire) exp_q.push_back(model(i_data, i_mode));
    stall_prev = !rst && o_valid && !o_ready;
    hold_d     = o_data;
    hold_s     = o_sat;
    @(posedge clk);
    if (rst) exp_q.delete();
    @(negedge clk);
  endtask

  // Driver: one transaction with o_ready=1, checking latency and the result.
  task automatic send_check(string tag, logic [NC*DW-1:0] d, logic m,
                            logic [DW:0] exp_d, logic exp_s);
    bit f;
    int tries, lat;
    o_ready = 1'b1;
    i_valid = 1'b1;
    i_data  = d;
    i_mode  = m;
    f = 1'b0;
    tries = 0;
    while (!f && tries < 20) begin
      cycle(f);
      tries++;
    end
    check({tag, "_accept"}, f, 1);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      cycle(f);
      lat++;
    end
    check({tag, "_latency"}, lat, S);
    check({tag, "_data"}, o_data, exp_d);
    check({tag, "_sat"}, o_sat, exp_s);
    cycle(f);
  endtask

  function automatic logic [NC*DW-1:0] rand_data();
    logic [NC*DW-1:0] d;
    int sel;
    for (int c = 0; c < NC; c++) begin
      sel = $urandom_range(0, 2);
      d[c*DW +: DW] = DW'($urandom_range(0, sel == 0 ? 32'h00FF : (sel == 1 ? 32'h07FF : 32'hFFFF)));
    end
    return d;
  endfunction

  logic [NC*DW-1:0] items [5];
  logic             item_m [5];
  logic [NC*DW-1:0] cur_d;
  logic             cur_m;

  initial begin
    bit f;
    int acc, n_sent, cyc;

    rst = 1'b1; i_valid = 1'b0; i_mode = 1'b0; i_data = '0; o_ready = 1'b1;
    @(negedge clk);
    cycle(f);
    cycle(f);
    rst = 1'b0;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_sat", o_sat, 0);
    check("rst_i_ready", i_ready, 1);

    // Directed arithmetic vectors
    send_check("sq_basic", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 1'b0, 17'h01E00, 1'b0);
    send_check("sum_basic", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 1'b1, 17'h00A00, 1'b0);
    send_check("sq_frac", {16'h0410, 16'h0320, 16'h0240, 16'h0180}, 1'b0, 17'h02195, 1'b0);
    send_check("sq_sat", {16'h8800, 16'h2500, 16'h1500, 16'h1100}, 1'b0, 17'h1FFFF, 1'b1);
    send_check("sum_sat", {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, 1'b1, 17'h1FFFF, 1'b1);

    // Back-pressure: fill with o_ready=0, then release
    for (int k = 0; k < 5; k++) begin
      items[k]  = rand_data();
      item_m[k] = 1'($urandom_range(0, 1));
    end
    o_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      i_valid = 1'b1;
      i_data  = items[acc];
      i_mode  = item_m[acc];
      cycle(f);
      if (f) acc++;
    end
    check("fill_accepted", acc, 3);
    check("fill_i_ready_low", i_ready, 0);
    o_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_valid = (acc < 5);
      if (acc < 5) begin
        i_data = items[acc];
        i_mode = item_m[acc];
      end
      check("release_consecutive", o_valid, 1);
      cycle(f);
      if (f) acc++;
    end
    for (int c = 0; c < 10 && acc < 5; c++) begin
      i_valid = 1'b1;
      i_data  = items[acc];
      i_mode  = item_m[acc];
      cycle(f);
      if (f) acc++;
    end
    i_valid = 1'b0;
    check("release_accepted", acc, 5);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) cycle(f);
    check("release_drained", exp_q.size(), 0);

    // Randomized traffic with random output stalls
    n_sent = 0;
    cyc = 0;
    cur_d = rand_data();
    cur_m = 1'($urandom_range(0, 1));
    i_valid = 1'b1;
    while (n_sent < 1000 && cyc < 20000) begin
      o_ready = 1'($urandom_range(0, 1));
      if (i_valid) begin
        i_data = cur_d;
        i_mode = cur_m;
      end else begin
        i_data = {$urandom, $urandom};
        i_mode = 1'($urandom_range(0, 1));
      end
      cycle(f);
      cyc++;
      if (f) begin
        n_sent++;
        cur_d = rand_data();
        cur_m = 1'($urandom_range(0, 1));
        i_valid = 1'b0;
      end else if (!i_valid) begin
        i_valid = 1'b1;
      end
    end
    i_valid = 1'b0;
    check("random_sent", n_sent, 1000);
    o_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() > 0; c++) cycle(f);
    check("random_drained", exp_q.size(), 0);

    // Reset mid-stream with two results in flight
    o_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10 && acc < 2; c++) begin
      i_valid = 1'b1;
      i_data  = rand_data();
      i_mode  = 1'b0;
      cycle(f);
      if (f) acc++;
    end
    check("flush_in_flight", acc, 2);
    rst = 1'b1;
    i_valid = 1'b1;
    i_data  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    cycle(f);
    rst = 1'b0;
    i_valid = 1'b0;
    check("flush_o_valid", o_valid, 0);
    check("flush_i_ready", i_ready, 1);
    o_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle(f);
    send_check("post_flush", {16'h0400, 16'h0300, 16'h0200, 16'h0100}, 1'b0, 17'h01E00, 1'b0);
    for (int c = 0; c < 4; c++) cycle(f);
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fxp_sumsq_pipe.md
FXP_SUMSQ_PIPE -- requirements
Module: fxp_sumsq_pipe

Interface
REQ-001 Parameter DATAWIDTH, default 16: width of each unsigned fixed-point input channel.
REQ-002 Parameter FRAC_BITS, default 8: fractional bits of inputs and of the result.
REQ-003 Parameter NUM_CH, default 4: channel count, legal range 1..16.
REQ-004 Parameter NUM_PIPELINE_STAGES, default 2: extra register stages after the compute stage, legal range 0..16.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 i_valid  input  1  input transaction present.
REQ-008 i_ready  output  1  block accepts input this cycle.
REQ-009 i_mode  input  1  0 = sum of squares, 1 = plain sum; sampled with the data.
REQ-010 i_data  input  NUM_CH*DATAWIDTH  packed channels, channel 0 in the LSBs.
REQ-011 o_valid  output  1  result present.
REQ-012 o_ready  input  1  downstream accepts result this cycle.
REQ-013 o_data  output  DATAWIDTH+1  result, same FRAC_BITS as the inputs.
REQ-014 o_sat  output  1  result was saturated.

Function
REQ-015 Input transfer: i_valid=1 and i_ready=1 on the same edge; output transfer: o_valid=1 and o_ready=1.
REQ-016 Pipeline: S = NUM_PIPELINE_STAGES+1 register stages, each holding {valid, data, sat}.
REQ-017 Stage 1 captures the fully computed result; the later stages only carry it.
REQ-018 Mode 0: each channel squared at full 2*DATAWIDTH precision, shifted right by FRAC_BITS (truncate), all channels summed at full width.
REQ-019 Mode 1: all channels summed at full width, no shift.
REQ-020 Full-width sum > 2^(DATAWIDTH+1)-1: data = all ones and sat = 1; otherwise data = low DATAWIDTH+1 bits and sat = 0.
REQ-021 Stage k loads when it is empty or its contents leave that cycle (stage S leaves on output transfer; stage k<S leaves into k+1).
REQ-022 Bubbles collapse: an empty stage accepts from the stage before it even when o_ready=0.
REQ-023 i_ready = stage 1 empty, or stage 1 leaving this cycle; combinational from o_ready, no register.
REQ-024 Latency with o_ready held 1: result appears on o_valid exactly S cycles after the input-transfer edge.
REQ-025 Throughput with o_ready held 1: one result per cycle, results in input order.
REQ-026 Capacity: at most S transactions held; none lost or duplicated under any o_ready pattern.
REQ-027 While o_valid=1 and o_ready=0, o_data and o_sat hold stable.
REQ-028 Simultaneous input and output transfer when all stages are full is legal and keeps occupancy at S.
REQ-029 i_data and i_mode are don't-care when i_valid=0; no stage loads a valid entry from them.

Reset
REQ-030 While rst=1, all stage valid bits clear at the next edge, including mid-stream; in-flight data is discarded.
REQ-031 After reset: o_valid=0, o_data=0, o_sat=0.
REQ-032 i_ready reads 1 in the first cycle after rst deasserts.
REQ-033 An input presented while rst=1 is not accepted.

Verification (defaults; S=3)
REQ-034 Mode 0, channels 0..3 = 0x0100, 0x0200, 0x0300, 0x0400, o_ready=1 -> 3 cycles later o_data=0x01E00, o_sat=0.
REQ-035 Mode 1, same data -> o_data=0x00A00, o_sat=0; mode 0, data 0x0180, 0x0240, 0x0320, 0x0410 -> o_data=0x02195, o_sat=0.
REQ-036 Mode 0, data 0x1100, 0x1500, 0x2500, 0x8800 -> o_data=0x1FFFF, o_sat=1; mode 1, all channels 0xFFFF -> o_data=0x1FFFF, o_sat=1.
REQ-037 o_ready=0 while 5 back-to-back inputs are offered:
  - i_ready drops after 3 accepted;
  - then o_ready=1: the 3 results come out in order on consecutive cycles, and the remaining 2 inputs are accepted.
REQ-038 Alternate i_valid 1/0 with o_ready toggling randomly (1000 transactions) -> results match a reference model in order, none lost; o_data stable whenever stalled.
REQ-039 Assert rst for one cycle while 2 results are in flight -> o_valid=0 next cycle, no stale result ever appears, and the next input returns 3 cycles after acceptance.
